// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one tagged memory port between the data-side
// requester (port 0) and the instruction fetch requester (port 1).
// Requests are granted and forwarded combinationally. Load tags are
// recorded in an owner table, and returning data is routed to the owning
// port by tag.
module mem_bus_arbiter #(
    parameter int XLEN         = 32,
    parameter int NUM_TAGS     = 15,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [1:0]      req0_command,
    input  logic [XLEN-1:0] req0_addr,
    input  logic [63:0]     req0_data,
    input  logic [1:0]      req0_size,
    input  logic [1:0]      req1_command,
    input  logic [XLEN-1:0] req1_addr,
    input  logic [63:0]     req1_data,
    input  logic [1:0]      req1_size,
    input  logic [3:0]      mem2proc_response,
    input  logic [63:0]     mem2proc_data,
    input  logic [3:0]      mem2proc_tag,
    output logic [1:0]      proc2mem_command,
    output logic [XLEN-1:0] proc2mem_addr,
    output logic [63:0]     proc2mem_data,
    output logic [1:0]      proc2mem_size,
    output logic [3:0]      resp0,
    output logic [3:0]      resp1,
    output logic [63:0]     data0,
    output logic [3:0]      tag0,
    output logic [63:0]     data1,
    output logic [3:0]      tag1,
    output logic [3:0]      pending0,
    output logic [3:0]      pending1,
    output logic            tag_err
);

    localparam logic [1:0] BUS_NONE = 2'd0;
    localparam logic [1:0] BUS_LOAD = 2'd1;

    // Tag 0 means "none"; tags above NUM_TAGS have no table entry.
    function automatic logic tag_ok(input logic [3:0] t);
        return (t != 4'd0) && ({28'd0, t} <= 32'(NUM_TAGS));
    endfunction

    logic [2:0]          starve_q, starve_d;
    logic [NUM_TAGS:0]   valid_q, valid_d;
    logic [NUM_TAGS:0]   owner_q, owner_d;
    logic [3:0]          pending0_q, pending0_d;
    logic [3:0]          pending1_q, pending1_d;
    logic                tag_err_q, tag_err_d;

    logic req0_s, req1_s, grant0_s, grant1_s;
    logic hit_s, hit_owner_s, unowned_s;
    logic alloc_s;
    logic inc0_s, dec0_s, inc1_s, dec1_s;

    // Grant selection: port 0 by default, port 1 once it has starved.
    always_comb begin
        req0_s   = (req0_command != BUS_NONE);
        req1_s   = (req1_command != BUS_NONE);
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (reset) begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end else if (req1_s && (!req0_s || ({29'd0, starve_q} >= 32'(STARVE_LIMIT)))) begin
            grant1_s = 1'b1;
        end else begin
            grant0_s = req0_s;
        end
    end

    // Forward the granted request and steer the acceptance back to it.
    always_comb begin
        proc2mem_command = BUS_NONE;
        proc2mem_addr    = '0;
        proc2mem_data    = 64'd0;
        proc2mem_size    = 2'd0;
        resp0            = 4'd0;
        resp1            = 4'd0;
        if (grant1_s) begin
            proc2mem_command = req1_command;
            proc2mem_addr    = req1_addr;
            proc2mem_data    = req1_data;
            proc2mem_size    = req1_size;
            resp1            = mem2proc_response;
        end else if (grant0_s) begin
            proc2mem_command = req0_command;
            proc2mem_addr    = req0_addr;
            proc2mem_data    = req0_data;
            proc2mem_size    = req0_size;
            resp0            = mem2proc_response;
        end else begin
            proc2mem_command = BUS_NONE;
        end
    end

    // Return routing: look up the pre-edge owner of the returning tag.
    always_comb begin
        hit_s       = 1'b0;
        hit_owner_s = 1'b0;
        unowned_s   = 1'b0;
        tag0        = 4'd0;
        tag1        = 4'd0;
        data0       = 64'd0;
        data1       = 64'd0;
        if (!reset && (mem2proc_tag != 4'd0)) begin
            if (tag_ok(mem2proc_tag) && valid_q[mem2proc_tag]) begin
                hit_s       = 1'b1;
                hit_owner_s = owner_q[mem2proc_tag];
                data0       = mem2proc_data;
                data1       = mem2proc_data;
                if (owner_q[mem2proc_tag]) begin
                    tag1 = mem2proc_tag;
                end else begin
                    tag0 = mem2proc_tag;
                end
            end else begin
                unowned_s = 1'b1;
            end
        end else begin
            hit_s = 1'b0;
        end
    end

    // Next state of the owner table, pending counts, starvation and error flag.
    always_comb begin
        alloc_s    = (grant0_s || grant1_s) && (proc2mem_command == BUS_LOAD) &&
                     tag_ok(mem2proc_response);
        valid_d    = valid_q;
        owner_d    = owner_q;
        // A free and an allocation of the same tag resolve to the allocation.
        if (hit_s) begin
            valid_d[mem2proc_tag] = 1'b0;
        end else begin
            valid_d = valid_q;
        end
        if (alloc_s) begin
            valid_d[mem2proc_response] = 1'b1;
            owner_d[mem2proc_response] = grant1_s;
        end else begin
            owner_d = owner_d;
        end

        inc0_s = alloc_s && grant0_s;
        inc1_s = alloc_s && grant1_s;
        dec0_s = hit_s && !hit_owner_s;
        dec1_s = hit_s && hit_owner_s;

        case ({inc0_s, dec0_s})
            2'b10:   pending0_d = pending0_q + 4'd1;
            2'b01:   pending0_d = pending0_q - 4'd1;
            default: pending0_d = pending0_q;
        endcase
        case ({inc1_s, dec1_s})
            2'b10:   pending1_d = pending1_q + 4'd1;
            2'b01:   pending1_d = pending1_q - 4'd1;
            default: pending1_d = pending1_q;
        endcase

        // Starvation: count denied cycles; a rejected grant neither counts nor clears.
        if (!req1_s) begin
            starve_d = 3'd0;
        end else if (!grant1_s) begin
            starve_d = (starve_q == 3'd7) ? 3'd7 : starve_q + 3'd1;
        end else if (mem2proc_response != 4'd0) begin
            starve_d = 3'd0;
        end else begin
            starve_d = starve_q;
        end

        tag_err_d = tag_err_q | unowned_s;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            starve_q   <= 3'd0;
            valid_q    <= '0;
            owner_q    <= '0;
            pending0_q <= 4'd0;
            pending1_q <= 4'd0;
            tag_err_q  <= 1'b0;
        end else begin
            starve_q   <= starve_d;
            valid_q    <= valid_d;
            owner_q    <= owner_d;
            pending0_q <= pending0_d;
            pending1_q <= pending1_d;
            tag_err_q  <= tag_err_d;
        end
    end

    assign pending0 = pending0_q;
    assign pending1 = pending1_q;
    assign tag_err  = tag_err_q;

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single tagged memory port (`proc2mem_*` / `mem2proc_*`) between two requesters: port 0 is the data cache/LSQ, port 1 is the instruction fetch cache.
- Selects one request per cycle and forwards it combinationally to memory.
- Records which port owns each issued load tag.
- Routes returning tagged data back to the owning port only.
- Sits between the core's cache controllers and the `mem` model.

Parameters:
- XLEN, 32, address width.
- NUM_TAGS, 15, number of nonzero memory tags (tag 0 means "none").
- STARVE_LIMIT, 4, consecutive denied cycles after which port 1 gets priority.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req0_command  in  2  port 0 bus command: BUS_NONE=0, BUS_LOAD=1, BUS_STORE=2.
- req0_addr  in  XLEN  port 0 address.
- req0_data  in  64  port 0 store data.
- req0_size  in  2  port 0 MEM_SIZE.
- req1_command  in  2  port 1 bus command (same encoding).
- req1_addr  in  XLEN  port 1 address.
- req1_data  in  64  port 1 store data.
- req1_size  in  2  port 1 MEM_SIZE.
- mem2proc_response  in  4  tag accepted by memory this cycle; 0 = rejected.
- mem2proc_data  in  64  returning load data.
- mem2proc_tag  in  4  tag of returning data; 0 = none.
- proc2mem_command  out  2  forwarded command.
- proc2mem_addr  out  XLEN  forwarded address.
- proc2mem_data  out  64  forwarded data.
- proc2mem_size  out  2  forwarded size.
- resp0  out  4  mem2proc_response when port 0 is granted, else 0.
- resp1  out  4  mem2proc_response when port 1 is granted, else 0.
- data0  out  64  mem2proc_data, qualified by tag0.
- tag0  out  4  mem2proc_tag when owned by port 0, else 0.
- data1  out  64  mem2proc_data, qualified by tag1.
- tag1  out  4  mem2proc_tag when owned by port 1, else 0.
- pending0  out  4  outstanding loads owned by port 0.
- pending1  out  4  outstanding loads owned by port 1.
- tag_err  out  1  sticky flag: data returned for an unowned tag.

Behaviour:
- **Grant (combinational).**
  - Default: port 0 wins when both command ≠ BUS_NONE.
  - If `starve_cnt` ≥ STARVE_LIMIT, port 1 wins instead.
  - With a single requester, that requester wins.
  - With no requester, command = BUS_NONE and addr/data/size = 0.
  - Outputs mirror the granted port's command/addr/data/size in the same cycle.
- **Response routing.** `resp0`/`resp1` equal `mem2proc_response` for the granted port only; the other port sees 0 and must retry, since memory accepts nothing from it.
- **starve_cnt** (3-bit register, saturating at 7):
  - increments when port 1 requests and is not granted;
  - clears when port 1 is granted with nonzero response, or when port 1 is idle;
  - holds when port 1 is granted but rejected (response = 0).
- **Owner table.** NUM_TAGS entries indexed by tag, each {valid, owner}.
  - On a granted BUS_LOAD with response ≠ 0: set entry[response] = {1, grant_id} at the clock edge.
  - Stores never allocate.
- **Return routing.** When `mem2proc_tag` ≠ 0 and entry[tag].valid:
  - drive `tag0` or `tag1` (per owner) = `mem2proc_tag` combinationally;
  - drive both `data0` and `data1` = `mem2proc_data` (consumers qualify with their tag);
  - clear the entry at the edge.
- **Unowned return.** When `mem2proc_tag` ≠ 0 and the entry is invalid: `tag0` = `tag1` = 0 and `tag_err` is set (sticky until reset).
- **Same-tag free and allocate in one cycle.** If the same tag is freed by a return and re-allocated by a response in the same cycle, allocation wins: entry valid with the new owner. The return still routes to the old owner using the pre-edge table.
- **pending0/pending1.**
  - increment on allocate and decrement on free for the respective owner;
  - a simultaneous allocate and free on the same port leaves the count unchanged;
  - width 4, never exceeding NUM_TAGS.
- **Reset.**
  - Table cleared, `starve_cnt` = 0, `pending0`/`pending1` = 0, `tag_err` = 0.
  - All combinational outputs are 0 while reset = 1; command = BUS_NONE.
  - Reset mid-transaction drops all ownership; later returns of old tags raise `tag_err` only after reset deasserts.
- **Latency.** Request path is 0 cycles. Data return path is 0 cycles from `mem2proc_tag`.

Test Plan:
- Port 0 LOAD addr 0x100, memory responds tag 3, later returns tag 3 with data 0xDEAD → `resp0`=3, `resp1`=0, `pending0`=1 then 0, `tag0`=3, `data0`=0xDEAD, `tag1`=0.
- Both ports LOAD every cycle, memory always accepts → port 0 granted for 4 cycles, port 1 granted on the 5th, `starve_cnt` back to 0; grant pattern repeats (4:1).
- Port 1 granted, memory responds 0 → `resp1`=0, no table entry, `pending1` stays 0, `starve_cnt` holds.
- Tag 5 owned by port 1 returns in the same cycle port 0 load is accepted with tag 5 → `tag1`=5 this cycle; next cycle entry 5 is owned by port 0, `pending1`−1, `pending0`+1.
- Port 0 STORE accepted with tag 2 → `resp0`=2, `pending0`=0; a later `mem2proc_tag`=2 sets `tag_err`=1, with `tag0`=`tag1`=0.
- Three loads outstanding, reset asserted for 1 cycle → `pending0`/`pending1`=0, `tag_err`=0, command = BUS_NONE; a subsequent return of an old tag sets `tag_err`.
